// File: rtl/cpu_control.sv
// Multi-cycle instruction sequencer: fetch, decode, execute / load-wait, halt.
// Optional branch support (BEQ/JMP and the flags register) is enabled by CPU_CONTROL_BRANCH_EN.
module cpu_control #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PC_WIDTH          = 8,
    parameter int ALU_CONTROL_SIZE  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic                         imem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    output logic                         dmem_req,
    input  logic                         dmem_ack,
    input  logic [3:0]                   alu_flags,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         write_enable,
    output logic                         data_control,
    output logic [ALU_CONTROL_SIZE-1:0]  control,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         halted
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEMWAIT = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t                         state_reg;
    logic [PC_WIDTH-1:0]            pc_reg;
    logic [INSTRUCTION_WIDTH-1:0]   ir_reg;

    logic [3:0]          opcode;
    logic                is_alu;
    logic                is_load;
    logic                is_halt;
    logic                branch_take;
    logic [PC_WIDTH-1:0] branch_target;

    assign opcode        = ir_reg[INSTRUCTION_WIDTH-1 -: 4];
    assign is_alu        = ~opcode[3];
    assign is_load       = (opcode == 4'h8);
    assign is_halt       = (opcode == 4'hF);
    assign branch_target = ir_reg[PC_WIDTH-1:0];

`ifdef CPU_CONTROL_BRANCH_EN
    logic [3:0] flags_reg;
    logic       unused_flags;

    // Z is the only flag the sequencer consumes; N, C and V are kept for completeness.
    assign branch_take  = (opcode == 4'hA) || ((opcode == 4'h9) && flags_reg[2]);
    assign unused_flags = ^{flags_reg[3], flags_reg[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= '0;
        end else if (state_reg == S_EXECUTE) begin
            flags_reg <= alu_flags;
        end
    end
`else
    logic unused_flags;

    assign branch_take  = 1'b0;
    assign unused_flags = ^alu_flags;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_reg    <= imem_rdata;
                        pc_reg    <= pc_reg + PC_WIDTH'(1);
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        state_reg <= S_HALT;
                    end else if (is_alu) begin
                        state_reg <= S_EXECUTE;
                    end else if (is_load) begin
                        state_reg <= S_MEMWAIT;
                    end else begin
                        // BEQ, JMP and NOP all return straight to fetch.
                        if (branch_take) begin
                            pc_reg <= branch_target;
                        end
                        state_reg <= S_FETCH;
                    end
                end
                S_EXECUTE: state_reg <= S_FETCH;
                S_MEMWAIT: begin
                    if (dmem_ack) begin
                        state_reg <= S_FETCH;
                    end
                end
                S_HALT:    state_reg <= S_HALT;
                default:   state_reg <= S_FETCH;
            endcase
        end
    end

    // Strobes decode straight from the state register; only the load write follows dmem_ack.
    assign imem_req     = (state_reg == S_FETCH);
    assign imem_addr    = pc_reg;
    assign pc           = pc_reg;
    assign instruction  = ir_reg;
    assign dmem_req     = (state_reg == S_MEMWAIT);
    assign data_control = (state_reg == S_MEMWAIT) && dmem_ack;
    assign write_enable = (state_reg == S_EXECUTE) || data_control;
    assign control      = (state_reg == S_EXECUTE) ? ALU_CONTROL_SIZE'(opcode) : '0;
    assign halted       = (state_reg == S_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: expected fetches and register writes are queued
// from a small program model and compared as the sequencer produces them.
module tb_cpu_control;

    localparam int IW         = 32;
    localparam int PW         = 8;
    localparam int CW         = 4;
    localparam int DMEM_DELAY = 4;

    localparam logic [3:0] OP_LOAD = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_NOP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          dmem_req;
    logic          dmem_ack;
    logic [3:0]    alu_flags;
    logic [IW-1:0] instruction;
    logic          write_enable;
    logic          data_control;
    logic [CW-1:0] control;
    logic [PW-1:0] pc;
    logic          halted;

    cpu_control #(
        .INSTRUCTION_WIDTH(IW),
        .PC_WIDTH(PW),
        .ALU_CONTROL_SIZE(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req),
        .dmem_ack(dmem_ack),
        .alu_flags(alu_flags),
        .instruction(instruction),
        .write_enable(write_enable),
        .data_control(data_control),
        .control(control),
        .pc(pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction memory and a datapath stand-in: only ALU op 7 produces Z=1.
    logic [31:0] prog [256];
    assign imem_rdata = prog[imem_addr];
    assign alu_flags  = (control == 4'h7) ? 4'b0100 : 4'b0000;

    typedef struct {
        logic [7:0] addr;
        int         gap;
    } fetch_t;

    typedef struct {
        logic       dc;
        logic [3:0] ctl;
        int         lat;
    } wr_t;

    fetch_t exp_fetch[$];
    wr_t    exp_wr[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_fetch_cyc = 0;
    int dreq_cnt = 0;
    int dcnt = 0;
    bit fetch_chk_en = 1'b1;
    bit dmem_auto = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] tgt);
        return {op, 20'h0, tgt};
    endfunction

    // Walks the program once, as the sequencer should, and fills both queues.
    task automatic build_expected();
        logic [7:0]  a;
        logic [7:0]  nxt;
        logic [31:0] w;
        logic [3:0]  op;
        bit          first;
        bit          z;
        int          gap;
        a = 8'h00; first = 1'b1; z = 1'b0; gap = -1;
        for (int n = 0; n < 600; n++) begin
            exp_fetch.push_back('{a, gap});
            w  = (a == 8'h00 && !first) ? mk(OP_HALT, 8'h00) : prog[a];
            op = w[31:28];
            if (op == OP_HALT) break;
            if (!op[3]) begin
                exp_wr.push_back('{1'b0, op, 2});
                z   = (op == 4'h7);
                gap = 3;
            end else if (op == OP_LOAD) begin
                exp_wr.push_back('{1'b1, 4'h0, 2 + DMEM_DELAY});
                gap = 3 + DMEM_DELAY;
            end else begin
                gap = 2;
            end
            nxt = a + 8'h01;
`ifdef CPU_CONTROL_BRANCH_EN
            if ((op == OP_BEQ && z) || op == OP_JMP) nxt = w[7:0];
`endif
            a = nxt;
            first = 1'b0;
        end
    endtask

    // Load-data responder: ack arrives DMEM_DELAY cycles after the request rises.
    initial begin
        dmem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dmem_auto) begin
                if (dmem_req) dcnt++;
                else dcnt = 0;
                dmem_ack = dmem_req && (dcnt == DMEM_DELAY + 1);
            end else begin
                dcnt = 0;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        wr_t    e;
        fetch_t f;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (dmem_req) dreq_cnt++;
                if (!write_enable) begin
                    check("ctl_idle", 32'(control), 32'h0);
                    check("dc_idle", 32'(data_control), 32'h0);
                end else if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 32'h1, 32'h0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_dc", 32'(data_control), 32'(e.dc));
                    check("wr_ctl", 32'(control), 32'(e.ctl));
                    check("wr_lat", 32'(cyc - last_fetch_cyc), 32'(e.lat));
                    if (e.dc) check("dreq_len", 32'(dreq_cnt), 32'(DMEM_DELAY + 1));
                end
                if (halted) check("halt_quiet", {29'h0, imem_req, dmem_req, write_enable}, 32'h0);
                if (!dmem_req) dreq_cnt = 0;
                if (imem_req && imem_ack) begin
                    if (fetch_chk_en) begin
                        if (exp_fetch.size() == 0) begin
                            check("fetch_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
                        end else begin
                            f = exp_fetch.pop_front();
                            check("fetch_addr", 32'(imem_addr), 32'(f.addr));
                            if (f.gap > 0) check("fetch_gap", 32'(cyc - last_fetch_cyc), 32'(f.gap));
                        end
                    end
                    last_fetch_cyc = cyc;
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = mk(OP_NOP, 8'h00);
        prog[0]     = mk(4'h2, 8'h00);
        prog[1]     = mk(OP_LOAD, 8'h00);
        prog[2]     = mk(4'h7, 8'h00);
        prog[3]     = mk(OP_BEQ, 8'h40);
        prog[8'h40] = mk(4'h1, 8'h00);
        prog[8'h41] = mk(OP_BEQ, 8'h80);
        prog[8'h42] = mk(OP_JMP, 8'hFE);
        build_expected();

        // Asynchronous reset state.
        #2 rst_n = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_ir", instruction, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_we", 32'(write_enable), 32'h0);
        check("rst_dmem_req", 32'(dmem_req), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h1);

        // Main program run with imem_ack tied high.
        imem_ack = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("c0_imem_req", 32'(imem_req), 32'h1);
        check("c0_imem_addr", 32'(imem_addr), 32'h0);
        @(negedge clk);
        check("c1_we", 32'(write_enable), 32'h0);
        prog[0] = mk(OP_HALT, 8'h00);
        @(negedge clk);
        check("c2_we", 32'(write_enable), 32'h1);
        check("c2_ctl", 32'(control), 32'h2);
        check("c2_pc", 32'(pc), 32'h1);
        for (int i = 0; i < 3000 && (exp_fetch.size() + exp_wr.size()) != 0; i++) @(negedge clk);
        check("run_drained", 32'(exp_fetch.size() + exp_wr.size()), 32'h0);

        // HALT is sticky and ignores both acks.
        repeat (4) @(negedge clk);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc), 32'h1);
        dmem_auto = 1'b0;
        @(posedge clk);
        #1 dmem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("halt_hold", 32'(halted), 32'h1);
        dmem_ack     = 1'b0;
        imem_ack     = 1'b0;
        fetch_chk_en = 1'b0;

        // Reset pulse leaves HALT and restarts fetch at 0.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("pulse_halted", 32'(halted), 32'h0);
        check("pulse_pc", 32'(pc), 32'h0);
        #2 rst_n = 1'b1;
        #1;
        check("restart_req", 32'(imem_req), 32'h1);
        check("restart_addr", 32'(imem_addr), 32'h0);

        // Reset during MEMWAIT with dmem_ack arriving in the same cycle.
        prog[0] = mk(OP_LOAD, 8'h00);
        @(posedge clk);
        #1 imem_ack = 1'b1;
        for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
        check("memwait_seen", 32'(dmem_req), 32'h1);
        @(posedge clk);
        #1;
        dmem_ack = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("abort_we", 32'(write_enable), 32'h0);
        check("abort_dc", 32'(data_control), 32'h0);
        check("abort_pc", 32'(pc), 32'h0);
        check("abort_fetch", 32'(imem_req), 32'h1);
        check("abort_dmem_req", 32'(dmem_req), 32'h0);
        dmem_ack = 1'b0;
        imem_ack = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_req", 32'(imem_req), 32'h1);
        check("post_abort_addr", 32'(imem_addr), 32'h0);

        // One more ALU instruction after the abandoned load.
        prog[0] = mk(4'h3, 8'h00);
        exp_wr.push_back('{1'b0, 4'h3, 2});
        @(posedge clk);
        #1 imem_ack = 1'b1;
        for (int i = 0; i < 10 && exp_wr.size() != 0; i++) @(negedge clk);
        check("final_drained", 32'(exp_wr.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
